or1200_rf_banked: RTL and testbench
===================================

// Module: or1200_rf_banked
// PURPOSE
//  Parametrised register file with NRP sync read ports and NSB banks of 2**AW regs.
//  Adds same-cycle write bypass, a dedicated debug SPR read path, and a bank-copy engine.
//  Sits between ID (reads) and WB (writes) in the or1200 pipeline.
//  Bank switching serves fast exception entry.
// PARAMETERS
//  DW   32  data width
//  AW   5   register address bits (2**AW regs per bank); AW+BW <= 10
//  BW   1   bank-select bits; NSB = 2**BW banks
//  NRP  2   number of pipeline read ports
// PORTS
//  clk              in   1         clock; all state on rising edge
//  rst              in   1         asynchronous active-low reset
//  we               in   1         pipeline write request (WB)
//  addrw            in   AW        pipeline write register, active bank
//  dataw            in   DW        pipeline write data
//  wb_freeze        in   1         WB stalled: pipeline write suppressed
//  flushpipe        in   1         flush: next unfrozen WB write suppressed
//  id_freeze        in   1         ID stalled: read ports hold
//  rd_en            in   NRP       per-port read enable
//  rd_addr          in   NRP*AW    port i address at [i*AW +: AW]
//  rd_data          out  NRP*DW    port i data at [i*DW +: DW], registered
//  bank_load        in   1         load active bank from bank_sel
//  bank_sel         in   BW        new active bank
//  cur_bank         out  BW        active bank
//  copy_req         in   1         start copy copy_src -> copy_dst
//  copy_src         in   BW        copy source bank
//  copy_dst         in   BW        copy destination bank
//  copy_busy        out  1         copy in progress
//  copy_done        out  1         1-cycle pulse when copy completes
//  spr_cs           in   1         SPR access select
//  spr_write        in   1         SPR write (else read)
//  spr_addr         in   16        SPR address
//  spr_dat_i        in   DW        SPR write data
//  spr_dat_o        out  DW        SPR read data, registered
//  gpr_written_to   out  1         committed write this cycle (comb)
//  gpr_written_addr out  BW+AW     {bank,reg} of committed write
//  gpr_written_data out  DW        committed write data
// BEHAVIOUR
//  Reset: all regs 0, rd_data/spr_dat_o 0, cur_bank 0, FSM IDLE, copy_* 0, we_allow 1.
//  Reg 0 of every bank reads 0 and is never written (writes to reg 0 dropped).
//  we_allow: when ~wb_freeze, <= ~flushpipe; held while wb_freeze.
//  spr_valid = spr_cs & spr_addr[15:10]==6'b000001; bank=spr_addr[AW+BW-1:AW], reg=spr_addr[AW-1:0].
//  Committed write (one/cycle): SPR write if spr_valid&spr_write, else pipeline write if
//   we&~wb_freeze&we_allow into cur_bank. SPR wins; colliding pipeline write is lost.
//  Read port i: if rd_en[i]&~id_freeze, rd_data_i <= cur_bank[rd_addr_i] next edge; else hold.
//   Bypass: committed write same cycle, same bank+reg, reg!=0 -> port gets new data.
//  SPR read: spr_valid&~spr_write -> spr_dat_o <= entry next edge (bypass rule applies);
//   no pipeline read port is disturbed.
//  bank_load: cur_bank <= bank_sel next edge; reads/writes that cycle use old bank.
//  Copy FSM: IDLE --copy_req--> COPY (cnt=1, busy=1); per cycle dst[cnt]<=src[cnt], cnt++.
//   Latch src/dst on accept. After cnt==2**AW-1: IDLE, copy_done pulse, busy=0.
//   Latency 2**AW-1 cycles (31 default). copy_req ignored while busy.
//   src==dst: no writes; done pulses the cycle after accept.
//  Coherence in COPY: committed write to src bank also written to dst same reg.
//   Committed write to dst reg==cnt overrides copy beat.
//  Reset mid-copy: FSM to IDLE, no done pulse, array cleared.
// TESTING
//  Write r5=0xDEADBEEF bank0; read port1 r5 next cycle -> rd_data1=0xDEADBEEF one cycle later.
//  Same-cycle write r7=0x1234 and read r7 on both ports -> both return 0x1234 (bypass).
//  Write r0=0xFFFF_FFFF via pipeline and via SPR 0x400 -> reads of r0 return 0.
//  flushpipe=1 (wb_freeze=0), then we=1 r3=0x55 -> r3 stays 0; next write r3=0x66 lands.
//  Fill bank0 r1..r31=idx, copy_req 0->1 -> busy 31 cycles, done pulse, bank1 r1..r31=idx.
//  During copy write bank0 r31=0xAA -> bank1 r31=0xAA at done; rst low mid-copy -> busy=0.

Source files
------------

// File: rtl/or1200_rf_banked.sv
// Banked GPR file for the or1200 pipeline: NRP registered read ports, one committed
// write per cycle with same-cycle bypass, a debug SPR window and a bank-copy engine.
module or1200_rf_banked #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int BW  = 1,
  parameter int NRP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     addrw,
  input  logic [DW-1:0]     dataw,
  input  logic              wb_freeze,
  input  logic              flushpipe,
  input  logic              id_freeze,
  input  logic [NRP-1:0]    rd_en,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP*DW-1:0] rd_data,
  input  logic              bank_load,
  input  logic [BW-1:0]     bank_sel,
  output logic [BW-1:0]     cur_bank,
  input  logic              copy_req,
  input  logic [BW-1:0]     copy_src,
  input  logic [BW-1:0]     copy_dst,
  output logic              copy_busy,
  output logic              copy_done,
  input  logic              spr_cs,
  input  logic              spr_write,
  input  logic [15:0]       spr_addr,
  input  logic [DW-1:0]     spr_dat_i,
  output logic [DW-1:0]     spr_dat_o,
  output logic              gpr_written_to,
  output logic [BW+AW-1:0]  gpr_written_addr,
  output logic [DW-1:0]     gpr_written_data
);

  localparam int IW = AW + BW;
  localparam int NE = 2 ** IW;

  typedef enum logic {IDLE, COPY} state_e;

  logic [DW-1:0] mem_q [NE];
  logic [DW-1:0] rd_data_q [NRP];
  logic [IW-1:0] rd_idx [NRP];
  logic [DW-1:0] spr_dat_q;
  logic [BW-1:0] cur_bank_q;
  logic          we_allow_q;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] src_q, src_d, dst_q, dst_d;
  logic          done_q, done_d;

  logic          spr_valid, spr_wr, pipe_wr;
  logic [IW-1:0] spr_idx;
  logic          c_en, m_en, b_en;
  logic [IW-1:0] c_idx, m_idx, b_idx, b_src;
  logic [DW-1:0] c_data;

  assign spr_valid = spr_cs && (spr_addr[15:10] == 6'b000001);
  assign spr_idx   = spr_addr[IW-1:0];
  assign spr_wr    = spr_valid && spr_write;
  assign pipe_wr   = we && !wb_freeze && we_allow_q;

  generate
    if (IW < 10) begin : g_spr_pad
      logic spr_addr_unused;
      assign spr_addr_unused = ^spr_addr[9:IW];
    end
  endgenerate

  // SPR write takes the single write slot; a colliding pipeline write is lost.
  always_comb begin
    c_idx  = spr_wr ? spr_idx : {cur_bank_q, addrw};
    c_data = spr_wr ? spr_dat_i : dataw;
    c_en   = (spr_wr || pipe_wr) && (c_idx[AW-1:0] != '0);
  end

  // Mirror writes into the source bank while copying so dst ends up coherent.
  always_comb begin
    b_en  = (state_q == COPY);
    b_idx = {dst_q, cnt_q};
    b_src = {src_q, cnt_q};
    m_idx = {dst_q, c_idx[AW-1:0]};
    m_en  = b_en && c_en && (c_idx[IW-1:AW] == src_q);
  end

  always_comb begin
    for (int i = 0; i < NRP; i++) rd_idx[i] = {cur_bank_q, rd_addr[i*AW +: AW]};
  end

  // NOTE: every FSM output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (copy_req) begin
        src_d = copy_src;
        dst_d = copy_dst;
        cnt_d = AW'(1);
        if (copy_src == copy_dst) done_d  = 1'b1;
        else                      state_d = COPY;
      end
      COPY: begin
        cnt_d = cnt_q + AW'(1);
        if (&cnt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      done_q     <= 1'b0;
      cur_bank_q <= '0;
      we_allow_q <= 1'b1;
      spr_dat_q  <= '0;
      for (int i = 0; i < NRP; i++) rd_data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      done_q  <= done_d;
      if (bank_load) cur_bank_q <= bank_sel;
      if (!wb_freeze) we_allow_q <= !flushpipe;
      if (spr_valid && !spr_write)
        spr_dat_q <= (c_en && c_idx == spr_idx) ? c_data : mem_q[spr_idx];
      for (int i = 0; i < NRP; i++)
        if (rd_en[i] && !id_freeze)
          rd_data_q[i] <= (c_en && c_idx == rd_idx[i]) ? c_data : mem_q[rd_idx[i]];
    end
  end

  // NOTE: the array is reset explicitly because it must read as zero after reset,
  // including an abandoned copy; register 0 is simply never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < NE; e++) mem_q[e] <= '0;
    end else begin
      for (int e = 0; e < NE; e++) begin
        if (c_en && c_idx == IW'(e))      mem_q[e] <= c_data;
        else if (m_en && m_idx == IW'(e)) mem_q[e] <= c_data;
        else if (b_en && b_idx == IW'(e)) mem_q[e] <= mem_q[b_src];
      end
    end
  end

  generate
    for (genvar g = 0; g < NRP; g++) begin : g_rd
      assign rd_data[g*DW +: DW] = rd_data_q[g];
    end
  endgenerate

  assign cur_bank         = cur_bank_q;
  assign copy_busy        = (state_q == COPY);
  assign copy_done        = done_q;
  assign spr_dat_o        = spr_dat_q;
  assign gpr_written_to   = c_en;
  assign gpr_written_addr = c_idx;
  assign gpr_written_data = c_data;

endmodule

// File: tb/tb_or1200_rf_banked.sv
// Directed self-checking bench for or1200_rf_banked (default parameters).
module tb_or1200_rf_banked;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  addrw;
  logic [31:0] dataw;
  logic        wb_freeze, flushpipe, id_freeze;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        bank_load;
  logic [0:0]  bank_sel, cur_bank;
  logic        copy_req;
  logic [0:0]  copy_src, copy_dst;
  logic        copy_busy, copy_done;
  logic        spr_cs, spr_write;
  logic [15:0] spr_addr;
  logic [31:0] spr_dat_i, spr_dat_o;
  logic        gpr_written_to;
  logic [5:0]  gpr_written_addr;
  logic [31:0] gpr_written_data;

  int checks = 0;
  int errors = 0;

  or1200_rf_banked dut (
    .clk(clk), .rst(rst), .we(we), .addrw(addrw), .dataw(dataw),
    .wb_freeze(wb_freeze), .flushpipe(flushpipe), .id_freeze(id_freeze),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .bank_load(bank_load), .bank_sel(bank_sel), .cur_bank(cur_bank),
    .copy_req(copy_req), .copy_src(copy_src), .copy_dst(copy_dst),
    .copy_busy(copy_busy), .copy_done(copy_done),
    .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr),
    .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o),
    .gpr_written_to(gpr_written_to), .gpr_written_addr(gpr_written_addr),
    .gpr_written_data(gpr_written_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pwrite(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addrw = a; dataw = d;
    tick();
    we = 1'b0;
  endtask

  task automatic sprw(input logic [15:0] a, input logic [31:0] d);
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_dat_i = d;
    tick();
    spr_cs = 1'b0; spr_write = 1'b0;
  endtask

  task automatic sprr(input logic [15:0] a);
    spr_cs = 1'b1; spr_write = 1'b0; spr_addr = a;
    tick();
    spr_cs = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    rd_en = 2'b11; rd_addr = {a1, a0};
    tick();
    rd_en = 2'b00;
  endtask

  initial begin
    int n;
    rst = 1'b0; we = 1'b0; addrw = '0; dataw = '0;
    wb_freeze = 1'b0; flushpipe = 1'b0; id_freeze = 1'b0;
    rd_en = '0; rd_addr = '0; bank_load = 1'b0; bank_sel = '0;
    copy_req = 1'b0; copy_src = '0; copy_dst = '0;
    spr_cs = 1'b0; spr_write = 1'b0; spr_addr = '0; spr_dat_i = '0;
    tick(); tick();
    check("reset_rd_data", rd_data, 64'h0);
    check("reset_spr_dat", spr_dat_o, 32'h0);
    check("reset_cur_bank", cur_bank, 1'b0);
    check("reset_busy_done", {copy_busy, copy_done}, 2'b00);
    rst = 1'b1;
    tick();

    pwrite(5'd5, 32'hDEADBEEF);
    rd_en = 2'b10; rd_addr = {5'd5, 5'd0};
    tick(); rd_en = 2'b00;
    check("read_r5_port1", rd_data[63:32], 32'hDEADBEEF);

    we = 1'b1; addrw = 5'd7; dataw = 32'h1234;
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    #1;
    check("written_to", gpr_written_to, 1'b1);
    check("written_addr_data", {gpr_written_addr, gpr_written_data}, {6'h07, 32'h1234});
    tick(); we = 1'b0; rd_en = 2'b00;
    check("bypass_r7_both", rd_data, {32'h1234, 32'h1234});

    pwrite(5'd0, 32'hFFFFFFFF);
    sprw(16'h0400, 32'hFFFFFFFF);
    we = 1'b1; addrw = 5'd0; dataw = 32'hFFFFFFFF;
    rd2(5'd0, 5'd0);
    we = 1'b0;
    check("r0_reads_zero", rd_data, 64'h0);

    flushpipe = 1'b1;
    tick();
    flushpipe = 1'b0;
    pwrite(5'd3, 32'h55);
    rd2(5'd3, 5'd5);
    check("flush_drops_write", rd_data, {32'hDEADBEEF, 32'h0});
    pwrite(5'd3, 32'h66);
    rd2(5'd3, 5'd3);
    check("write_after_flush", rd_data, {32'h66, 32'h66});

    sprr(16'h0405);
    check("spr_read_r5", spr_dat_o, 32'hDEADBEEF);
    check("spr_read_ports_hold", rd_data, {32'h66, 32'h66});

    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 16'h0409; spr_dat_i = 32'h99;
    we = 1'b1; addrw = 5'd10; dataw = 32'h77;
    tick();
    spr_cs = 1'b0; spr_write = 1'b0; we = 1'b0;
    rd2(5'd9, 5'd10);
    check("spr_wins_collision", rd_data, {32'h0, 32'h99});

    id_freeze = 1'b1;
    rd2(5'd5, 5'd5);
    id_freeze = 1'b0;
    check("id_freeze_hold", rd_data, {32'h0, 32'h99});

    for (int i = 1; i < 32; i++) pwrite(5'(i), 32'(i));
    copy_src = 1'b0; copy_dst = 1'b1; copy_req = 1'b1;
    tick();
    copy_req = 1'b0;
    n = copy_busy ? 1 : 0;
    check("copy_busy_after_accept", copy_busy, 1'b1);
    for (int k = 0; k < 40; k++) begin
      if (k == 10) pwrite(5'd31, 32'hAA);
      else if (k == 12) pwrite(5'd3, 32'hAB);
      else tick();
      if (!copy_busy) break;
      n++;
    end
    check("copy_busy_cycles", n, 31);
    check("copy_done_pulse", copy_done, 1'b1);
    tick();
    check("copy_done_one_cycle", copy_done, 1'b0);

    bank_load = 1'b1; bank_sel = 1'b1;
    tick();
    bank_load = 1'b0;
    check("bank_switch", cur_bank, 1'b1);
    rd2(5'd1, 5'd17);
    check("bank1_r1_r17", rd_data, {32'd17, 32'd1});
    rd2(5'd30, 5'd31);
    check("bank1_r30_r31", rd_data, {32'hAA, 32'd30});
    rd2(5'd3, 5'd0);
    check("bank1_mirror_r3", rd_data, {32'h0, 32'hAB});

    we = 1'b1; addrw = 5'd2; dataw = 32'h22;
    #1;
    check("written_addr_bank1", gpr_written_addr, 6'h22);
    tick(); we = 1'b0;
    sprr(16'h0402);
    check("spr_bank0_r2", spr_dat_o, 32'd2);
    sprr(16'h0422);
    check("spr_bank1_r2", spr_dat_o, 32'h22);

    copy_src = 1'b1; copy_dst = 1'b1; copy_req = 1'b1;
    tick();
    copy_req = 1'b0;
    check("same_bank_done", {copy_busy, copy_done}, 2'b01);
    tick();
    check("same_bank_done_end", copy_done, 1'b0);

    copy_src = 1'b0; copy_dst = 1'b1; copy_req = 1'b1;
    tick();
    copy_req = 1'b0;
    tick(); tick(); tick();
    check("busy_before_reset", copy_busy, 1'b1);
    rst = 1'b0;
    #2;
    check("reset_mid_copy", {copy_busy, copy_done, cur_bank}, 3'b000);
    tick();
    rst = 1'b1;
    tick();
    check("no_done_after_reset", {copy_busy, copy_done}, 2'b00);
    rd2(5'd1, 5'd31);
    check("array_cleared", rd_data, 64'h0);
    sprr(16'h0421);
    check("array_cleared_bank1", spr_dat_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
